// File: rtl/imem_loader.sv
// imem_loader: instruction RAM filled over a valid/ready port; serves PMIPSL0 fetches and sequences its reset
module imem_loader #(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int IW         = 17,
  parameter int RST_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [16:0]   imemaddr,
  output logic [IW-1:0] imemrdata,
  input  logic          load_start,
  input  logic          run_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          cpu_reset,
  output logic [AW:0]   load_count,
  output logic          load_err
);
  localparam int CW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {HOLD, LOAD, RELEASE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] hold_cnt;
  logic [IW-1:0] mem [DEPTH];
  logic accept, full, hi_zero, unused_lsb;
  logic [AW-1:0] idx;
  assign accept     = load_valid & load_ready;
  assign full       = load_count == (AW+1)'(DEPTH);
  assign load_ready = state == LOAD;
  assign cpu_reset  = state != RUN;
  assign idx        = imemaddr[AW:1];
  assign hi_zero    = ~|(imemaddr >> (AW + 1));
  assign unused_lsb = imemaddr[0];
  assign imemrdata  = (state == RUN && hi_zero && {1'b0, idx} < load_count) ? mem[idx] : '0;
  // next-state: load_start beats run_start in HOLD; last accepted word ends a load
  always_comb begin
    state_nx = state;
    case (state)
      HOLD:    state_nx = load_start ? LOAD : run_start ? RELEASE : HOLD;
      LOAD:    state_nx = (accept && load_last) ? RELEASE : LOAD;
      RELEASE: state_nx = (hold_cnt == CW'(RST_CYCLES - 1)) ? RUN : RELEASE;
      RUN:     state_nx = load_start ? LOAD : RUN;
    endcase
  end
  // state, hold counter and load bookkeeping; count doubles as write pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= HOLD;
      hold_cnt   <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= (state == RELEASE) ? hold_cnt + 1'b1 : '0;
      if (state != LOAD && state_nx == LOAD) begin
        load_count <= '0;
        load_err   <= 1'b0;
      end else if (accept) begin
        if (full) load_err <= 1'b1;
        else load_count <= load_count + 1'b1;
      end
    end
  end
  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (accept && !full) mem[load_count[AW-1:0]] <= load_data;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, release timing, reads, overflow and reset abort
module tb_imem_loader;
  logic clk = 0, reset;
  logic [16:0] imemaddr, imemrdata, load_data;
  logic load_start, run_start, load_valid, load_last, load_ready, cpu_reset, load_err;
  logic [7:0] load_count;
  logic [16:0] s_addr, s_rdata, s_data;
  logic s_start, s_valid, s_last, s_ready, s_cpu_reset, s_err;
  logic [2:0] s_count;
  int checks = 0, passes = 0;

  imem_loader u_dut (.clock(clk), .reset(reset), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .load_start(load_start), .run_start(run_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .cpu_reset(cpu_reset), .load_count(load_count),
    .load_err(load_err));

  imem_loader #(.DEPTH(4), .AW(2)) u_small (.clock(clk), .reset(reset), .imemaddr(s_addr),
    .imemrdata(s_rdata), .load_start(s_start), .run_start(1'b0), .load_valid(s_valid),
    .load_data(s_data), .load_last(s_last), .load_ready(s_ready), .cpu_reset(s_cpu_reset),
    .load_count(s_count), .load_err(s_err));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [16:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    cyc();
    load_valid = 0; load_last = 0;
  endtask

  task automatic test_reset();
    reset = 1; imemaddr = 0; load_start = 0; run_start = 0; load_valid = 0; load_data = 0; load_last = 0;
    s_addr = 0; s_start = 0; s_valid = 0; s_data = 0; s_last = 0;
    repeat (2) cyc();
    reset = 0;
    cyc();
    checks++; if (cpu_reset !== 1'b1) $display("FAIL rst_cpu_reset act=%b exp=1", cpu_reset); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL rst_load_ready act=%b exp=0", load_ready); else passes++;
    checks++; if (load_count !== 8'd0) $display("FAIL rst_load_count act=%0d exp=0", load_count); else passes++;
    checks++; if (imemrdata !== 17'h0) $display("FAIL rst_rdata act=%h exp=0", imemrdata); else passes++;
  endtask

  task automatic test_load_run();
    load_start = 1; run_start = 1;
    cyc();
    load_start = 0; run_start = 0;
    checks++; if (load_ready !== 1'b1) $display("FAIL t2_start_wins act=%b exp=1", load_ready); else passes++;
    send(17'h0C283, 0);
    send(17'h0EB01, 0);
    send(17'h0CE07, 1);
    checks++; if (load_count !== 8'd3) $display("FAIL t2_count act=%0d exp=3", load_count); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL t2_ready_rel act=%b exp=0", load_ready); else passes++;
    repeat (3) cyc();
    checks++; if (cpu_reset !== 1'b1) $display("FAIL t2_hold3 act=%b exp=1", cpu_reset); else passes++;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t2_rd_hold act=%h exp=0", imemrdata); else passes++;
    cyc();
    checks++; if (cpu_reset !== 1'b0) $display("FAIL t2_release act=%b exp=0", cpu_reset); else passes++;
    imemaddr = 0; #1;
    checks++; if (imemrdata !== 17'h0C283) $display("FAIL t2_rd0 act=%h exp=0c283", imemrdata); else passes++;
    imemaddr = 2; #1;
    checks++; if (imemrdata !== 17'h0EB01) $display("FAIL t2_rd2 act=%h exp=0eb01", imemrdata); else passes++;
    imemaddr = 4; #1;
    checks++; if (imemrdata !== 17'h0CE07) $display("FAIL t2_rd4 act=%h exp=0ce07", imemrdata); else passes++;
    imemaddr = 6; #1;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t2_rd6 act=%h exp=0", imemrdata); else passes++;
    imemaddr = 3; #1;
    checks++; if (imemrdata !== 17'h0EB01) $display("FAIL t2_rd3_odd act=%h exp=0eb01", imemrdata); else passes++;
    imemaddr = 17'h10002; #1;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t2_rd_upper act=%h exp=0", imemrdata); else passes++;
  endtask

  task automatic test_async_reset();
    imemaddr = 0;
    #3 reset = 1;
    #1;
    checks++; if (cpu_reset !== 1'b1) $display("FAIL t1_cpu_reset act=%b exp=1", cpu_reset); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL t1_ready act=%b exp=0", load_ready); else passes++;
    checks++; if (load_count !== 8'd0) $display("FAIL t1_count act=%0d exp=0", load_count); else passes++;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t1_rdata act=%h exp=0", imemrdata); else passes++;
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic test_backpressure();
    logic [16:0] words [3] = '{17'h00011, 17'h00022, 17'h00033};
    logic [7:0] exp_cnt [5] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    load_start = 1;
    cyc();
    load_start = 0;
    for (int i = 0; i < 5; i++) begin
      load_valid = (i % 2 == 0);
      load_data = load_valid ? words[i/2] : 17'h15555;
      load_last = (i == 4);
      cyc();
      checks++; if (load_count !== exp_cnt[i]) $display("FAIL t3_count%0d act=%0d exp=%0d", i, load_count, exp_cnt[i]); else passes++;
    end
    load_valid = 0; load_last = 0;
    repeat (4) cyc();
    checks++; if (cpu_reset !== 1'b0) $display("FAIL t3_run act=%b exp=0", cpu_reset); else passes++;
    for (int i = 0; i < 4; i++) begin
      imemaddr = 17'(2 * i); #1;
      checks++;
      if (imemrdata !== (i < 3 ? words[i] : 17'h0)) $display("FAIL t3_rd%0d act=%h exp=%h", i, imemrdata, (i < 3 ? words[i] : 17'h0));
      else passes++;
    end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_cnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    s_start = 1;
    cyc();
    s_start = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1; s_data = 17'h00100 + 17'(i); s_last = (i == 5);
      cyc();
      checks++; if (s_count !== exp_cnt[i]) $display("FAIL t4_count%0d act=%0d exp=%0d", i, s_count, exp_cnt[i]); else passes++;
      checks++; if (s_err !== (i >= 4)) $display("FAIL t4_err%0d act=%b exp=%b", i, s_err, i >= 4); else passes++;
    end
    s_valid = 0; s_last = 0;
    repeat (4) cyc();
    checks++; if (s_cpu_reset !== 1'b0) $display("FAIL t4_run act=%b exp=0", s_cpu_reset); else passes++;
    s_addr = 6; #1;
    checks++; if (s_rdata !== 17'h00103) $display("FAIL t4_rd6 act=%h exp=00103", s_rdata); else passes++;
    s_addr = 8; #1;
    checks++; if (s_rdata !== 17'h0) $display("FAIL t4_rd8 act=%h exp=0", s_rdata); else passes++;
  endtask

  task automatic test_reset_mid_load();
    load_start = 1;
    cyc();
    load_start = 0;
    send(17'h0AAAA, 0);
    send(17'h05555, 0);
    checks++; if (load_count !== 8'd2) $display("FAIL t5_count2 act=%0d exp=2", load_count); else passes++;
    #3 reset = 1;
    #1;
    checks++; if (load_count !== 8'd0) $display("FAIL t5_count0 act=%0d exp=0", load_count); else passes++;
    checks++; if (load_ready !== 1'b0) $display("FAIL t5_ready act=%b exp=0", load_ready); else passes++;
    cyc();
    reset = 0;
    run_start = 1;
    cyc();
    run_start = 0;
    repeat (4) cyc();
    checks++; if (cpu_reset !== 1'b0) $display("FAIL t5_run act=%b exp=0", cpu_reset); else passes++;
    imemaddr = 0; #1;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t5_rd0 act=%h exp=0", imemrdata); else passes++;
    imemaddr = 2; #1;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t5_rd2 act=%h exp=0", imemrdata); else passes++;
  endtask

  task automatic test_reload();
    run_start = 1;
    cyc();
    run_start = 0;
    checks++; if (cpu_reset !== 1'b0) $display("FAIL t6_run_ignored act=%b exp=0", cpu_reset); else passes++;
    load_start = 1;
    cyc();
    load_start = 0;
    checks++; if (cpu_reset !== 1'b1) $display("FAIL t6_cpu_reset act=%b exp=1", cpu_reset); else passes++;
    checks++; if (load_ready !== 1'b1) $display("FAIL t6_ready act=%b exp=1", load_ready); else passes++;
    send(17'h1FFFF, 1);
    repeat (4) cyc();
    checks++; if (load_count !== 8'd1) $display("FAIL t6_count act=%0d exp=1", load_count); else passes++;
    imemaddr = 0; #1;
    checks++; if (imemrdata !== 17'h1FFFF) $display("FAIL t6_rd0 act=%h exp=1ffff", imemrdata); else passes++;
    imemaddr = 2; #1;
    checks++; if (imemrdata !== 17'h0) $display("FAIL t6_rd2 act=%h exp=0", imemrdata); else passes++;
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_async_reset();
    test_backpressure();
    test_overflow();
    test_reset_mid_load();
    test_reload();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
